// File: rtl/seq_chunk_adder_if.sv
// Handshake and data bundle for seq_chunk_adder: operand request side and
// registered result side.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in CHUNK bits per
// clock, keeping the inter-chunk carry in a register.
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
      $error("seq_chunk_adder: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              accept_s;
  logic              step_s;
  logic              last_s;

  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  acc_r;
  logic              carry_r;
  logic [IDXW-1:0]   idx_r;

  logic [CHUNK:0]    chunk_sum_s;
  logic [WIDTH-1:0]  acc_next_s;
  logic              msb_cin_s;
  logic              ovf_s;

  logic              busy_r;
  logic              done_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;

  // Chunk adder over the low bits of the operand shift registers.
  always_comb begin
    chunk_sum_s = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};
    // Partial sums enter from the top so the last chunk leaves acc fully aligned.
    acc_next_s  = (acc_r >> CHUNK) | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << (WIDTH - CHUNK));
    // Carry into the MSB recovered from the MSB sum bit; only used on the last chunk.
    msb_cin_s   = chunk_sum_s[CHUNK-1] ^ a_r[CHUNK-1] ^ b_r[CHUNK-1];
    ovf_s       = msb_cin_s ^ chunk_sum_s[CHUNK];
  end

  // Next-state and control strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
          accept_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          next_state_s = DONE;
          last_s       = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          next_state_s = RUN;
          accept_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Operand capture, chunk stepping and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_r     <= bus.a;
      b_r     <= bus.b;
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= bus.cin;
      idx_r   <= {IDXW{1'b0}};
    end else if (step_s) begin
      a_r     <= a_r >> CHUNK;
      b_r     <= b_r >> CHUNK;
      acc_r   <= acc_next_s;
      carry_r <= chunk_sum_s[CHUNK];
      idx_r   <= idx_r + IDXW'(1);
      if (last_s) begin
        sum_r  <= acc_next_s;
        cout_r <= chunk_sum_s[CHUNK];
        ovf_r  <= ovf_s;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: directed cases on a CHUNK=2 instance
// plus a random sweep over CHUNK = 1, 2, 4, 8.
module tb_seq_chunk_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst_sw;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    int unsigned stamp;
  } exp_t;

  exp_t q[$];
  exp_t me;

  seq_chunk_adder_if #(.WIDTH(W)) if0 ();
  seq_chunk_adder #(.WIDTH(W), .CHUNK(2)) u_dut (.clk(clk), .rst(rst), .bus(if0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Main-DUT monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if0.done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", if0.done, 1'b0);
      end else begin
        me = q.pop_front();
        check("sum", if0.sum, me.sum);
        check("cout", if0.cout, me.cout);
        check("ovf", if0.ovf, me.ovf);
        check("latency", cyc - me.stamp, 5);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push,
                       input logic [7:0] s, input logic co, input logic ov);
    exp_t e;
    if0.start = 1'b1;
    if0.a     = a;
    if0.b     = b;
    if0.cin   = c;
    if (push) begin
      e.sum   = s;
      e.cout  = co;
      e.ovf   = ov;
      e.stamp = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    if0.start = 1'b0;
    if0.a     = 8'hEE;
    if0.b     = 8'h77;
    if0.cin   = ~c;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (if0.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, if0.done, 1'b1);
  endtask

  // Parameter sweep: one independent instance, scoreboard and stimulus per CHUNK.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int CH = 1 << g;
    localparam int NC = W / CH;
    seq_chunk_adder_if #(.WIDTH(W)) sif ();
    seq_chunk_adder #(.WIDTH(W), .CHUNK(CH)) u_sw (.clk(clk), .rst(rst_sw), .bus(sif));
    exp_t sq[$];
    exp_t se;
    logic fin = 1'b0;

    always @(negedge clk) begin
      if (sif.done === 1'b1) begin
        if (sq.size() == 0) begin
          check($sformatf("sweep%0d_unexpected_done", CH), sif.done, 1'b0);
        end else begin
          se = sq.pop_front();
          check($sformatf("sweep%0d_sum", CH), sif.sum, se.sum);
          check($sformatf("sweep%0d_cout", CH), sif.cout, se.cout);
          check($sformatf("sweep%0d_ovf", CH), sif.ovf, se.ovf);
          check($sformatf("sweep%0d_latency", CH), cyc - se.stamp, NC + 1);
        end
      end
    end

    initial begin
      exp_t        e;
      logic [8:0]  full;
      int          k;
      sif.start = 1'b0;
      sif.a     = 8'h00;
      sif.b     = 8'h00;
      sif.cin   = 1'b0;
      repeat (5) @(negedge clk);
      for (int n = 0; n < 200; n++) begin
        if (n == 0) begin
          sif.a = 8'hFF; sif.b = 8'hFF; sif.cin = 1'b1;
        end else if (n == 1) begin
          sif.a = 8'h80; sif.b = 8'h80; sif.cin = 1'b0;
        end else begin
          sif.a   = 8'($urandom);
          sif.b   = 8'($urandom);
          sif.cin = 1'($urandom_range(0, 1));
        end
        full    = {1'b0, sif.a} + {1'b0, sif.b} + {8'h00, sif.cin};
        e.sum   = full[7:0];
        e.cout  = full[8];
        e.ovf   = (sif.a[7] == sif.b[7]) && (full[7] != sif.a[7]);
        e.stamp = cyc;
        sq.push_back(e);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.a     = ~sif.a;
        k = 0;
        while (sif.done !== 1'b1 && k < 20) begin
          @(negedge clk);
          k++;
        end
        check($sformatf("sweep%0d_done_seen", CH), sif.done, 1'b1);
        @(negedge clk);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    rst       = 1'b1;
    rst_sw    = 1'b1;
    if0.start = 1'b0;
    if0.a     = 8'h00;
    if0.b     = 8'h00;
    if0.cin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", if0.busy, 1'b0);
    check("rst_done", if0.done, 1'b0);
    check("rst_sum", if0.sum, 8'h00);
    check("rst_cout", if0.cout, 1'b0);
    check("rst_ovf", if0.ovf, 1'b0);
    rst    = 1'b0;
    rst_sw = 1'b0;
    @(negedge clk);

    // Basic op: busy for four cycles, done on the fifth.
    issue(8'h3C, 8'h0F, 1'b0, 1'b1, 8'h4B, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("busy_run", if0.busy, 1'b1);
      check("done_low_run", if0.done, 1'b0);
      @(negedge clk);
    end
    check("busy_done_cycle", if0.busy, 1'b0);
    check("done_pulse", if0.done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", if0.done, 1'b0);

    issue(8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_done("wrap");
    @(negedge clk);
    issue(8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    wait_done("pos_ovf");
    @(negedge clk);
    issue(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    wait_done("neg_ovf");
    @(negedge clk);

    // Back-to-back: second start issued during the done cycle.
    issue(8'hA5, 8'h5A, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    wait_done("b2b_first");
    issue(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
    check("b2b_hold0", if0.sum, 8'hFF);
    if0.start = 1'b1;
    if0.a     = 8'hFF;
    if0.b     = 8'hFF;
    if0.cin   = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    check("b2b_hold1", if0.sum, 8'hFF);
    @(negedge clk);
    check("b2b_hold2", if0.sum, 8'hFF);
    @(negedge clk);
    check("b2b_hold3", if0.sum, 8'hFF);
    wait_done("b2b_second");
    @(negedge clk);

    // Reset during the second RUN cycle aborts without a done pulse.
    issue(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", if0.busy, 1'b0);
    check("abort_done", if0.done, 1'b0);
    check("abort_sum", if0.sum, 8'h00);
    repeat (6) @(negedge clk);
    issue(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    wait_done("after_abort");
    @(negedge clk);

    // Reset wins over a simultaneous start.
    rst       = 1'b1;
    if0.start = 1'b1;
    if0.a     = 8'h11;
    if0.b     = 8'h22;
    @(negedge clk);
    rst       = 1'b0;
    if0.start = 1'b0;
    check("rst_start_busy", if0.busy, 1'b0);
    check("rst_start_sum", if0.sum, 8'h00);
    repeat (8) @(negedge clk);

    t = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("sweep_complete",
          {28'h0, g_sweep[3].fin, g_sweep[2].fin, g_sweep[1].fin, g_sweep[0].fin}, 32'hF);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
